// File: rtl/bus_cycle_ctrl_if.sv
// Core-request and 68000-style bus signal bundle for bus_cycle_ctrl.
// The master view belongs to the controller; the slave view to the core plus bus environment.
interface bus_cycle_ctrl_if;
  logic        req;
  logic        we;
  logic        size;
  logic [23:0] addr;
  logic [15:0] wdata;
  logic        ack;
  logic [15:0] rdata;
  logic        err;
  logic        addr_err;
  logic        busy;
  logic [22:0] A;
  logic        AS;
  logic        UDS;
  logic        LDS;
  logic        RW;
  logic [15:0] D_OUT;
  logic        D_OE;
  logic [15:0] D_IN;
  logic        DTACK;
  logic        BERR;
  logic        BR;
  logic        BGACK;
  logic        BG;
  logic        BUS_OWN;

  modport master (
    input  req, we, size, addr, wdata, D_IN, DTACK, BERR, BR, BGACK,
    output ack, rdata, err, addr_err, busy, A, AS, UDS, LDS, RW, D_OUT, D_OE, BG, BUS_OWN
  );

  modport slave (
    output req, we, size, addr, wdata, D_IN, DTACK, BERR, BR, BGACK,
    input  ack, rdata, err, addr_err, busy, A, AS, UDS, LDS, RW, D_OUT, D_OE, BG, BUS_OWN
  );
endinterface

// File: rtl/bus_cycle_ctrl.sv
// Runs one byte/word 68000-style asynchronous bus cycle per core request and
// hands the bus to external masters over BR/BG/BGACK while idle.
module bus_cycle_ctrl #(
  parameter int TIMEOUT = 64
) (
  input logic              CLK,
  input logic              RESET,
  bus_cycle_ctrl_if.master bus
);

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_ADDR     = 3'd1;
  localparam logic [2:0] ST_STROBE   = 3'd2;
  localparam logic [2:0] ST_WAIT     = 3'd3;
  localparam logic [2:0] ST_DONE     = 3'd4;
  localparam logic [2:0] ST_GRANT    = 3'd5;
  localparam logic [2:0] ST_RELEASED = 3'd6;

  localparam int               CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT);

  logic [2:0]       state_r;
  logic [2:0]       state_nxt_s;
  logic [CNT_W-1:0] cnt_r;
  logic             we_r;
  logic             size_r;
  logic             a0_r;

  logic        accept_s;
  logic        addr_err_s;
  logic        timeout_s;
  logic        we_cur_s;
  logic        strobe_nxt_s;
  logic        drive_nxt_s;
  logic        read_ok_s;
  logic [15:0] wdata_bus_s;
  logic [15:0] rdata_cap_s;

  assign accept_s     = (state_r == ST_IDLE) & ~bus.BR & bus.req;
  assign addr_err_s   = bus.size & bus.addr[0];
  assign timeout_s    = (cnt_r == CNT_LAST);
  assign we_cur_s     = accept_s ? bus.we : we_r;
  assign strobe_nxt_s = (state_nxt_s == ST_STROBE) | (state_nxt_s == ST_WAIT);
  assign drive_nxt_s  = we_cur_s & ((state_nxt_s == ST_ADDR) | strobe_nxt_s);
  assign read_ok_s    = (state_r == ST_WAIT) & ~bus.BERR & bus.DTACK & ~we_r;
  assign wdata_bus_s  = bus.size ? bus.wdata : {bus.wdata[7:0], bus.wdata[7:0]};

  // Byte lane selection for read data: even byte rides UDS (D[15:8]), odd byte LDS (D[7:0]).
  always_comb begin
    rdata_cap_s = 16'h0000;
    if (size_r) begin
      rdata_cap_s = bus.D_IN;
    end else if (a0_r) begin
      rdata_cap_s = {8'h00, bus.D_IN[7:0]};
    end else begin
      rdata_cap_s = {8'h00, bus.D_IN[15:8]};
    end
  end

  // Next-state decode; BR is honoured only from IDLE and outranks a same-cycle req.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.BR) begin
          state_nxt_s = ST_GRANT;
        end else if (bus.req) begin
          state_nxt_s = addr_err_s ? ST_DONE : ST_ADDR;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ADDR:   state_nxt_s = ST_STROBE;
      ST_STROBE: state_nxt_s = ST_WAIT;
      ST_WAIT: begin
        if (bus.BERR || bus.DTACK || timeout_s) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_WAIT;
        end
      end
      ST_DONE:   state_nxt_s = ST_IDLE;
      ST_GRANT: begin
        if (bus.BGACK) begin
          state_nxt_s = ST_RELEASED;
        end else if (!bus.BR) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_GRANT;
        end
      end
      ST_RELEASED: begin
        if (!bus.BGACK) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_RELEASED;
        end
      end
      default:   state_nxt_s = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Request attributes kept for the strobe phase and read-data lane selection.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      we_r   <= 1'b0;
      size_r <= 1'b0;
      a0_r   <= 1'b0;
    end else if (accept_s) begin
      we_r   <= bus.we;
      size_r <= bus.size;
      a0_r   <= bus.addr[0];
    end
  end

  // WAIT-cycle counter; the timeout exit fires on the WAIT cycle where it reaches TIMEOUT.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      cnt_r <= '0;
    end else if (state_r == ST_STROBE) begin
      cnt_r <= '0;
    end else if ((state_r == ST_WAIT) && !timeout_s) begin
      cnt_r <= cnt_r + CNT_W'(1);
    end
  end

  // Registered outputs, loaded with the values belonging to the state being entered.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      bus.A        <= 23'h000000;
      bus.AS       <= 1'b0;
      bus.UDS      <= 1'b0;
      bus.LDS      <= 1'b0;
      bus.RW       <= 1'b1;
      bus.D_OUT    <= 16'h0000;
      bus.D_OE     <= 1'b0;
      bus.BG       <= 1'b0;
      bus.BUS_OWN  <= 1'b1;
      bus.ack      <= 1'b0;
      bus.rdata    <= 16'h0000;
      bus.err      <= 1'b0;
      bus.addr_err <= 1'b0;
      bus.busy     <= 1'b0;
    end else begin
      bus.ack     <= (state_nxt_s == ST_DONE);
      bus.busy    <= (state_nxt_s != ST_IDLE);
      bus.BG      <= (state_nxt_s == ST_GRANT);
      bus.BUS_OWN <= ~((state_nxt_s == ST_GRANT) | (state_nxt_s == ST_RELEASED));
      bus.AS      <= strobe_nxt_s;
      bus.UDS     <= strobe_nxt_s & (size_r | ~a0_r);
      bus.LDS     <= strobe_nxt_s & (size_r | a0_r);
      bus.D_OE    <= drive_nxt_s;

      if (accept_s && !addr_err_s) begin
        bus.A  <= bus.addr[23:1];
        bus.RW <= ~bus.we;
        if (bus.we) begin
          bus.D_OUT <= wdata_bus_s;
        end
      end else if (state_nxt_s == ST_DONE) begin
        bus.RW <= 1'b1;
      end

      if (state_nxt_s == ST_DONE) begin
        if (state_r == ST_IDLE) begin
          bus.err      <= 1'b1;
          bus.addr_err <= 1'b1;
          bus.rdata    <= 16'h0000;
        end else begin
          bus.err      <= bus.BERR | ~bus.DTACK;
          bus.addr_err <= 1'b0;
          bus.rdata    <= read_ok_s ? rdata_cap_s : 16'h0000;
        end
      end else begin
        bus.err      <= 1'b0;
        bus.addr_err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_bus_cycle_ctrl.sv
// Self-checking bench for bus_cycle_ctrl: directed scenarios plus randomized
// transfers scored against a transaction-level reference model.
module tb_bus_cycle_ctrl;

  localparam int TMO     = 8;
  localparam int K_DTACK = 0;
  localparam int K_BERR  = 1;
  localparam int K_BOTH  = 2;
  localparam int K_NONE  = 3;

  logic CLK = 1'b0;
  logic RESET;
  int   n_cmp = 0;
  int   n_bad = 0;

  bus_cycle_ctrl_if bif ();

  bus_cycle_ctrl #(.TIMEOUT(TMO)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bif)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    int          ack_n;
    logic        err;
    logic        addr_err;
    logic [15:0] rdata;
    logic [22:0] a;
    logic        rw;
    logic        as1;
    logic        doe1;
    logic [15:0] dout1;
    logic        busy1;
    logic        as2;
    logic        uds2;
    logic        lds2;
    logic        doe_wait;
    logic        doe_done;
    logic        as_ever;
    logic        busy_after;
  } obs_t;

  typedef struct packed {
    int          ack_n;
    logic        err;
    logic        addr_err;
    logic [15:0] rdata;
    logic [22:0] a;
    logic        rw;
    logic        uds;
    logic        lds;
    logic [15:0] dout;
    logic        read_ok;
    logic        strobes;
  } exp_t;

  // Transaction-level expectation: latency is 4 + number of WAIT cycles, or 1 for an address error.
  function automatic exp_t model(input logic we, input logic size, input logic [23:0] addr,
                                 input logic [15:0] wdata, input logic [15:0] din,
                                 input int kind, input int k);
    exp_t e;
    int   waits;
    e = '0;
    e.a    = addr[23:1];
    e.rw   = !we;
    e.uds  = size || !addr[0];
    e.lds  = size || addr[0];
    e.dout = size ? wdata : {wdata[7:0], wdata[7:0]};
    if (size && addr[0]) begin
      e.ack_n = 1; e.err = 1'b1; e.addr_err = 1'b1; e.strobes = 1'b0;
    end else begin
      e.strobes = 1'b1;
      if (kind != K_NONE && k <= TMO) begin
        waits = k; e.err = (kind != K_DTACK);
      end else begin
        waits = TMO; e.err = 1'b1;
      end
      e.ack_n   = 4 + waits;
      e.read_ok = !we && !e.err;
      if (e.read_ok) e.rdata = size ? din : (addr[0] ? {8'h00, din[7:0]} : {8'h00, din[15:8]});
    end
    return e;
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Drives one request, answers with DTACK/BERR on WAIT cycle k, records what the bus did.
  task automatic do_xfer(input logic we, input logic size, input logic [23:0] addr,
                         input logic [15:0] wdata, input logic [15:0] din,
                         input int kind, input int k, input int br_at, output obs_t o);
    int n;
    o = '0;
    o.ack_n = -1;
    bif.req = 1'b1; bif.we = we; bif.size = size; bif.addr = addr; bif.wdata = wdata; bif.D_IN = din;
    n = 0;
    while (n < 60) begin
      tick();
      n++;
      if (n == 1) begin
        o.a = bif.A; o.rw = bif.RW; o.as1 = bif.AS; o.doe1 = bif.D_OE; o.dout1 = bif.D_OUT; o.busy1 = bif.busy;
      end
      if (n == 2) begin
        o.as2 = bif.AS; o.uds2 = bif.UDS; o.lds2 = bif.LDS;
      end
      if (n == 3) o.doe_wait = bif.D_OE;
      if (bif.AS) o.as_ever = 1'b1;
      if (br_at != 0 && n == br_at) bif.BR = 1'b1;
      if (bif.ack) begin
        o.ack_n = n; o.err = bif.err; o.addr_err = bif.addr_err; o.rdata = bif.rdata; o.doe_done = bif.D_OE;
        break;
      end
      bif.DTACK = (kind == K_DTACK || kind == K_BOTH) && (n == 3 + k);
      bif.BERR  = (kind == K_BERR  || kind == K_BOTH) && (n == 3 + k);
    end
    bif.req = 1'b0; bif.DTACK = 1'b0; bif.BERR = 1'b0;
    tick();
    o.busy_after = bif.busy;
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    tick(); tick();
    n_cmp++; if (bif.A !== 23'h0)        begin n_bad++; $display("FAIL rst_A: got %h want 0", bif.A); end
    n_cmp++; if (bif.AS !== 1'b0)        begin n_bad++; $display("FAIL rst_AS: got %b want 0", bif.AS); end
    n_cmp++; if (bif.UDS !== 1'b0)       begin n_bad++; $display("FAIL rst_UDS: got %b want 0", bif.UDS); end
    n_cmp++; if (bif.LDS !== 1'b0)       begin n_bad++; $display("FAIL rst_LDS: got %b want 0", bif.LDS); end
    n_cmp++; if (bif.RW !== 1'b1)        begin n_bad++; $display("FAIL rst_RW: got %b want 1", bif.RW); end
    n_cmp++; if (bif.D_OUT !== 16'h0)    begin n_bad++; $display("FAIL rst_D_OUT: got %h want 0", bif.D_OUT); end
    n_cmp++; if (bif.D_OE !== 1'b0)      begin n_bad++; $display("FAIL rst_D_OE: got %b want 0", bif.D_OE); end
    n_cmp++; if (bif.BG !== 1'b0)        begin n_bad++; $display("FAIL rst_BG: got %b want 0", bif.BG); end
    n_cmp++; if (bif.BUS_OWN !== 1'b1)   begin n_bad++; $display("FAIL rst_BUS_OWN: got %b want 1", bif.BUS_OWN); end
    n_cmp++; if (bif.ack !== 1'b0)       begin n_bad++; $display("FAIL rst_ack: got %b want 0", bif.ack); end
    n_cmp++; if (bif.rdata !== 16'h0)    begin n_bad++; $display("FAIL rst_rdata: got %h want 0", bif.rdata); end
    n_cmp++; if (bif.err !== 1'b0)       begin n_bad++; $display("FAIL rst_err: got %b want 0", bif.err); end
    n_cmp++; if (bif.addr_err !== 1'b0)  begin n_bad++; $display("FAIL rst_addr_err: got %b want 0", bif.addr_err); end
    n_cmp++; if (bif.busy !== 1'b0)      begin n_bad++; $display("FAIL rst_busy: got %b want 0", bif.busy); end
    RESET = 1'b0;
    tick();
  endtask

  task automatic test_word_read();
    obs_t o;
    do_xfer(1'b0, 1'b1, 24'h000100, 16'h0000, 16'hBEEF, K_DTACK, 2, 0, o);
    n_cmp++; if (o.ack_n !== 6)          begin n_bad++; $display("FAIL wr_latency: got %0d want 6", o.ack_n); end
    n_cmp++; if (o.a !== 23'h000080)     begin n_bad++; $display("FAIL wr_A: got %h want 000080", o.a); end
    n_cmp++; if (o.rw !== 1'b1)          begin n_bad++; $display("FAIL wr_RW: got %b want 1", o.rw); end
    n_cmp++; if ({o.as2, o.uds2, o.lds2} !== 3'b111) begin n_bad++; $display("FAIL wr_strobes: got %b want 111", {o.as2, o.uds2, o.lds2}); end
    n_cmp++; if (o.rdata !== 16'hBEEF)   begin n_bad++; $display("FAIL wr_rdata: got %h want beef", o.rdata); end
    n_cmp++; if (o.err !== 1'b0)         begin n_bad++; $display("FAIL wr_err: got %b want 0", o.err); end
    n_cmp++; if (o.doe1 !== 1'b0)        begin n_bad++; $display("FAIL wr_D_OE: got %b want 0", o.doe1); end
  endtask

  task automatic test_byte_write();
    obs_t o;
    do_xfer(1'b1, 1'b0, 24'h000201, 16'h005A, 16'h0000, K_DTACK, 1, 0, o);
    n_cmp++; if ({o.uds2, o.lds2} !== 2'b01) begin n_bad++; $display("FAIL bw_lanes: got %b want 01", {o.uds2, o.lds2}); end
    n_cmp++; if (o.rw !== 1'b0)          begin n_bad++; $display("FAIL bw_RW: got %b want 0", o.rw); end
    n_cmp++; if (o.dout1 !== 16'h5A5A)   begin n_bad++; $display("FAIL bw_D_OUT: got %h want 5a5a", o.dout1); end
    n_cmp++; if ({o.doe1, o.doe_wait, o.doe_done} !== 3'b110) begin n_bad++; $display("FAIL bw_D_OE: got %b want 110", {o.doe1, o.doe_wait, o.doe_done}); end
    n_cmp++; if (o.ack_n !== 5)          begin n_bad++; $display("FAIL bw_latency: got %0d want 5", o.ack_n); end
    n_cmp++; if (o.err !== 1'b0)         begin n_bad++; $display("FAIL bw_err: got %b want 0", o.err); end
  endtask

  task automatic test_addr_err();
    obs_t o;
    do_xfer(1'b0, 1'b1, 24'h000003, 16'h0000, 16'h1111, K_DTACK, 0, 0, o);
    n_cmp++; if (o.ack_n !== 1)          begin n_bad++; $display("FAIL ae_latency: got %0d want 1", o.ack_n); end
    n_cmp++; if ({o.err, o.addr_err} !== 2'b11) begin n_bad++; $display("FAIL ae_flags: got %b want 11", {o.err, o.addr_err}); end
    n_cmp++; if (o.as_ever !== 1'b0)     begin n_bad++; $display("FAIL ae_no_AS: got %b want 0", o.as_ever); end
    n_cmp++; if (o.busy_after !== 1'b0)  begin n_bad++; $display("FAIL ae_idle: got %b want 0", o.busy_after); end
  endtask

  task automatic test_bus_error();
    obs_t o;
    do_xfer(1'b0, 1'b1, 24'h000040, 16'h0000, 16'h2222, K_BOTH, 0, 0, o);
    n_cmp++; if (o.ack_n !== 4)          begin n_bad++; $display("FAIL be_latency: got %0d want 4", o.ack_n); end
    n_cmp++; if ({o.err, o.addr_err} !== 2'b10) begin n_bad++; $display("FAIL be_flags: got %b want 10", {o.err, o.addr_err}); end
    do_xfer(1'b0, 1'b0, 24'h000041, 16'h0000, 16'h3333, K_NONE, 0, 0, o);
    n_cmp++; if (o.ack_n !== TMO + 4)    begin n_bad++; $display("FAIL to_latency: got %0d want %0d", o.ack_n, TMO + 4); end
    n_cmp++; if ({o.err, o.addr_err} !== 2'b10) begin n_bad++; $display("FAIL to_flags: got %b want 10", {o.err, o.addr_err}); end
    do_xfer(1'b0, 1'b0, 24'h000041, 16'h0000, 16'h3377, K_DTACK, TMO, 0, o);
    n_cmp++; if (o.ack_n !== TMO + 4)    begin n_bad++; $display("FAIL to_edge_latency: got %0d want %0d", o.ack_n, TMO + 4); end
    n_cmp++; if (o.err !== 1'b0)         begin n_bad++; $display("FAIL to_edge_err: got %b want 0", o.err); end
    n_cmp++; if (o.rdata !== 16'h0077)   begin n_bad++; $display("FAIL to_edge_rdata: got %h want 0077", o.rdata); end
  endtask

  task automatic test_grant();
    obs_t o;
    do_xfer(1'b0, 1'b1, 24'h000300, 16'h0000, 16'hCAFE, K_DTACK, 3, 4, o);
    n_cmp++; if (o.ack_n !== 7)          begin n_bad++; $display("FAIL gr_inflight_latency: got %0d want 7", o.ack_n); end
    n_cmp++; if (o.rdata !== 16'hCAFE)   begin n_bad++; $display("FAIL gr_inflight_rdata: got %h want cafe", o.rdata); end
    bif.req = 1'b1; bif.we = 1'b0; bif.size = 1'b1; bif.addr = 24'h000400; bif.D_IN = 16'h1234;
    tick();
    n_cmp++; if ({bif.BG, bif.BUS_OWN, bif.AS} !== 3'b100) begin n_bad++; $display("FAIL gr_grant: got BG/OWN/AS %b want 100", {bif.BG, bif.BUS_OWN, bif.AS}); end
    bif.BGACK = 1'b1; bif.BR = 1'b0;
    tick();
    n_cmp++; if ({bif.BG, bif.BUS_OWN} !== 2'b00) begin n_bad++; $display("FAIL gr_released: got BG/OWN %b want 00", {bif.BG, bif.BUS_OWN}); end
    tick(); tick();
    n_cmp++; if ({bif.BUS_OWN, bif.ack} !== 2'b00) begin n_bad++; $display("FAIL gr_hold: got OWN/ack %b want 00", {bif.BUS_OWN, bif.ack}); end
    bif.BGACK = 1'b0;
    tick();
    n_cmp++; if ({bif.BG, bif.BUS_OWN, bif.busy} !== 3'b010) begin n_bad++; $display("FAIL gr_return: got BG/OWN/busy %b want 010", {bif.BG, bif.BUS_OWN, bif.busy}); end
    do_xfer(1'b0, 1'b1, 24'h000400, 16'h0000, 16'h1234, K_DTACK, 0, 0, o);
    n_cmp++; if (o.ack_n !== 4)          begin n_bad++; $display("FAIL gr_pending_latency: got %0d want 4", o.ack_n); end
    n_cmp++; if (o.rdata !== 16'h1234)   begin n_bad++; $display("FAIL gr_pending_rdata: got %h want 1234", o.rdata); end
    bif.BR = 1'b1;
    tick();
    n_cmp++; if (bif.BG !== 1'b1)        begin n_bad++; $display("FAIL gr_br_bg: got %b want 1", bif.BG); end
    bif.BR = 1'b0;
    tick();
    n_cmp++; if ({bif.BG, bif.BUS_OWN, bif.busy} !== 3'b010) begin n_bad++; $display("FAIL gr_withdraw: got BG/OWN/busy %b want 010", {bif.BG, bif.BUS_OWN, bif.busy}); end
  endtask

  task automatic test_reset_mid();
    obs_t o;
    int   acks;
    bif.req = 1'b1; bif.we = 1'b1; bif.size = 1'b1; bif.addr = 24'h000010; bif.wdata = 16'hA5C3;
    tick(); tick();
    n_cmp++; if ({bif.AS, bif.D_OE} !== 2'b11) begin n_bad++; $display("FAIL rm_pre: got AS/D_OE %b want 11", {bif.AS, bif.D_OE}); end
    RESET = 1'b1;
    #1;
    n_cmp++; if ({bif.AS, bif.UDS, bif.LDS, bif.D_OE} !== 4'b0000) begin n_bad++; $display("FAIL rm_async: got AS/UDS/LDS/D_OE %b want 0000", {bif.AS, bif.UDS, bif.LDS, bif.D_OE}); end
    bif.req = 1'b0;
    tick(); tick();
    RESET = 1'b0;
    acks = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bif.ack) acks++;
    end
    n_cmp++; if (acks !== 0)             begin n_bad++; $display("FAIL rm_no_ack: got %0d acks want 0", acks); end
    do_xfer(1'b0, 1'b1, 24'h000020, 16'h0000, 16'h0F0F, K_DTACK, 1, 0, o);
    n_cmp++; if (o.ack_n !== 5)          begin n_bad++; $display("FAIL rm_after_latency: got %0d want 5", o.ack_n); end
    n_cmp++; if (o.rdata !== 16'h0F0F)   begin n_bad++; $display("FAIL rm_after_rdata: got %h want 0f0f", o.rdata); end
  endtask

  task automatic test_random();
    obs_t        o;
    exp_t        e;
    logic        we, size;
    logic [23:0] addr;
    logic [15:0] wdata, din;
    int          kind, k, r;
    for (int i = 0; i < 40; i++) begin
      we = 1'($urandom()); size = 1'($urandom());
      addr = 24'($urandom()); wdata = 16'($urandom()); din = 16'($urandom());
      r = $urandom_range(0, 9);
      kind = (r < 6) ? K_DTACK : (r < 8) ? K_BERR : (r == 8) ? K_BOTH : K_NONE;
      k = $urandom_range(0, 10);
      e = model(we, size, addr, wdata, din, kind, k);
      do_xfer(we, size, addr, wdata, din, kind, k, 0, o);
      n_cmp++; if (o.ack_n !== e.ack_n) begin n_bad++; $display("FAIL rnd%0d_latency: got %0d want %0d", i, o.ack_n, e.ack_n); end
      n_cmp++; if ({o.err, o.addr_err} !== {e.err, e.addr_err}) begin n_bad++; $display("FAIL rnd%0d_flags: got %b want %b", i, {o.err, o.addr_err}, {e.err, e.addr_err}); end
      n_cmp++; if (o.busy_after !== 1'b0) begin n_bad++; $display("FAIL rnd%0d_idle: got %b want 0", i, o.busy_after); end
      if (e.strobes) begin
        n_cmp++; if ({o.a, o.rw} !== {e.a, e.rw}) begin n_bad++; $display("FAIL rnd%0d_addr: got %h/%b want %h/%b", i, o.a, o.rw, e.a, e.rw); end
        n_cmp++; if ({o.as1, o.as2, o.uds2, o.lds2} !== {1'b0, 1'b1, e.uds, e.lds}) begin n_bad++; $display("FAIL rnd%0d_strobes: got %b want %b", i, {o.as1, o.as2, o.uds2, o.lds2}, {1'b0, 1'b1, e.uds, e.lds}); end
        n_cmp++; if ({o.busy1, o.doe1, o.doe_done} !== {1'b1, we, 1'b0}) begin n_bad++; $display("FAIL rnd%0d_oe: got %b want %b", i, {o.busy1, o.doe1, o.doe_done}, {1'b1, we, 1'b0}); end
        if (we) begin
          n_cmp++; if (o.dout1 !== e.dout) begin n_bad++; $display("FAIL rnd%0d_dout: got %h want %h", i, o.dout1, e.dout); end
        end
        if (e.read_ok) begin
          n_cmp++; if (o.rdata !== e.rdata) begin n_bad++; $display("FAIL rnd%0d_rdata: got %h want %h", i, o.rdata, e.rdata); end
        end
      end else begin
        n_cmp++; if (o.as_ever !== 1'b0) begin n_bad++; $display("FAIL rnd%0d_no_AS: got %b want 0", i, o.as_ever); end
      end
    end
  endtask

  initial begin
    RESET = 1'b1;
    bif.req = 1'b0; bif.we = 1'b0; bif.size = 1'b0; bif.addr = 24'h0; bif.wdata = 16'h0;
    bif.D_IN = 16'h0; bif.DTACK = 1'b0; bif.BERR = 1'b0; bif.BR = 1'b0; bif.BGACK = 1'b0;
    test_reset();
    test_word_read();
    test_byte_write();
    test_addr_err();
    test_bus_error();
    test_grant();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
